// File: rtl/ahb_arb_pkg.sv
// Shared constants, state encoding and default-width bus types for the AHB-Lite request arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping to 0.
module ahb_rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Shares one AHB-Lite master port between N_REQ requesters; single non-pipelined transfers,
// round-robin grant, response routed back to the winner only.
//
//   state   | meaning
//   IDLE    | no transfer in flight; grant a requester if any is valid
//   ADDR    | NONSEQ on the bus, waiting for hready to close the address phase
//   DATA    | data phase; wait for hready or give up after TIMEOUT low cycles
module ahb_req_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_W-1:0]       haddr,
  output logic                    hwrite,
  output logic [1:0]              htrans,
  output logic [2:0]              hsize,
  output logic [2:0]              hburst,
  output logic [DATA_W-1:0]       hwdata,
  input  logic [DATA_W-1:0]       hrdata,
  input  logic                    hready,
  input  logic                    hresp
);

  import ahb_arb_pkg::*;

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]  gnt_idx, gnt_idx_nxt;
  logic              lat_write, lat_write_nxt;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic [N_REQ-1:0]  req_ready_nxt, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt, hwdata_nxt;
  logic              rsp_err_nxt, hwrite_nxt;
  logic [ADDR_W-1:0] haddr_nxt;
  logic [1:0]        htrans_nxt;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  ahb_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    gnt_idx_nxt   = gnt_idx;
    lat_write_nxt = lat_write;
    lat_wdata_nxt = lat_wdata;
    wait_cnt_nxt  = wait_cnt;
    req_ready_nxt = '0;
    rsp_valid_nxt = '0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    haddr_nxt     = haddr;
    hwrite_nxt    = hwrite;
    htrans_nxt    = htrans;
    hwdata_nxt    = hwdata;

    case (state)
      ST_IDLE: begin
        htrans_nxt = HTRANS_IDLE;
        if (pick_any) begin
          req_ready_nxt = pick_grant;
          gnt_idx_nxt   = pick_idx;
          lat_write_nxt = req_write[pick_idx];
          lat_wdata_nxt = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          haddr_nxt     = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          hwrite_nxt    = req_write[pick_idx];
          htrans_nxt    = HTRANS_NONSEQ;
          rr_ptr_nxt    = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_nxt     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          htrans_nxt   = HTRANS_IDLE;
          if (lat_write) hwdata_nxt = lat_wdata;
          wait_cnt_nxt = '0;
          state_nxt    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hready) begin
          rsp_valid_nxt = ONE_HOT0 << gnt_idx;
          rsp_rdata_nxt = lat_write ? '0 : hrdata;
          rsp_err_nxt   = hresp;
          state_nxt     = ST_IDLE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th low cycle: abandon the slave and report an error
          rsp_valid_nxt = ONE_HOT0 << gnt_idx;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          state_nxt     = ST_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      haddr     <= '0;
      hwrite    <= 1'b0;
      htrans    <= HTRANS_IDLE;
      hwdata    <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      gnt_idx   <= gnt_idx_nxt;
      lat_write <= lat_write_nxt;
      lat_wdata <= lat_wdata_nxt;
      wait_cnt  <= wait_cnt_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      haddr     <= haddr_nxt;
      hwrite    <= hwrite_nxt;
      htrans    <= htrans_nxt;
      hwdata    <= hwdata_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter (N_REQ=2, TIMEOUT=16) with hand-computed expectations.
module tb_ahb_req_arbiter;
  import ahb_arb_pkg::*;

  localparam int N_REQ = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic [N_REQ-1:0]  req_valid, req_write;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]  req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize, hburst;
  logic [DW-1:0]     hwdata, hrdata;
  logic              hready, hresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  ahb_req_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)
  ) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input addr_t a, input data_t d);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // bounded wait for the next accept pulse, checking handshakes never overlap
  task automatic wait_grant(output logic [N_REQ-1:0] got);
    got = '0;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("no_overlap", 64'(|req_ready & |rsp_valid), 64'd0);
      if (req_ready != '0) begin
        got = req_ready;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    check({tag, "_haddr"},     64'(haddr),     64'd0);
    check({tag, "_hwrite"},    64'(hwrite),    64'd0);
    check({tag, "_htrans"},    64'(htrans),    64'd0);
    check({tag, "_hwdata"},    64'(hwdata),    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_REQ-1:0] g;
    hresetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    hrdata    = '0;
    hready    = 1'b1;
    hresp     = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    check("rst_hsize",  64'(hsize),  64'h2);
    check("rst_hburst", 64'(hburst), 64'h0);
    hresetn = 1'b1;

    // 1: zero-wait write from req0
    set_req(0, 1'b1, 32'h10, 32'hCAFE);
    tick();
    check("wr_ready",  64'(req_ready), 64'b01);
    check("wr_haddr",  64'(haddr),     64'h10);
    check("wr_htrans", 64'(htrans),    64'h2);
    check("wr_hwrite", 64'(hwrite),    64'h1);
    req_valid = '0;
    tick();
    check("wr_ready_pulse", 64'(req_ready), 64'd0);
    check("wr_htrans_idle", 64'(htrans),    64'h0);
    check("wr_hwdata",      64'(hwdata),    64'hCAFE);
    check("wr_no_rsp_yet",  64'(rsp_valid), 64'd0);
    tick();
    check("wr_rsp_valid", 64'(rsp_valid), 64'b01);
    check("wr_rsp_err",   64'(rsp_err),   64'd0);
    check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    check("wr_rsp_pulse", 64'(rsp_valid), 64'd0);

    // 2: read from req1 with three data-phase wait states
    set_req(1, 1'b0, 32'h20, 32'h0);
    tick();
    check("rd_ready", 64'(req_ready), 64'b10);
    check("rd_haddr", 64'(haddr),     64'h20);
    check("rd_hwrite", 64'(hwrite),   64'h0);
    req_valid = '0;
    tick();
    hready = 1'b0;
    hrdata = 32'h1234;
    for (int w = 0; w < 3; w++) begin
      tick();
      check("rd_wait_no_rsp", 64'(rsp_valid), 64'd0);
      check("rd_wait_haddr",  64'(haddr),     64'h20);
    end
    hready = 1'b1;
    tick();
    check("rd_rsp_valid", 64'(rsp_valid), 64'b10);
    check("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234);
    check("rd_rsp_err",   64'(rsp_err),   64'd0);
    tick();
    check("rd_rsp_pulse", 64'(rsp_valid), 64'd0);

    // 3: both requesters continuously valid -> alternating grants from pointer 0
    hrdata = 32'h5A5A;
    set_req(0, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b0, 32'h104, 32'h0);
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      check($sformatf("fair_grant%0d", k), 64'(g), (k % 2 == 0) ? 64'b01 : 64'b10);
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fair_tail_no_overlap", 64'(|req_ready & |rsp_valid), 64'd0);
    end

    // 4: timeout on a stuck read from req0
    set_req(0, 1'b0, 32'h40, 32'h0);
    tick();
    check("to_ready", 64'(req_ready), 64'b01);
    req_valid = '0;
    tick();
    hready = 1'b0;
    hrdata = 32'hDEAD;
    for (int w = 0; w < 15; w++) tick();
    check("to_no_rsp_after15", 64'(rsp_valid), 64'd0);
    tick();
    check("to_rsp_valid", 64'(rsp_valid), 64'b01);
    check("to_rsp_err",   64'(rsp_err),   64'd1);
    check("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
    hready = 1'b1;
    set_req(1, 1'b0, 32'h44, 32'h0);
    tick();
    check("to_next_ready", 64'(req_ready), 64'b10);
    req_valid = '0;
    tick();
    tick();
    check("to_next_rsp",   64'(rsp_valid), 64'b10);
    check("to_next_rdata", 64'(rsp_rdata), 64'hDEAD);
    check("to_next_err",   64'(rsp_err),   64'd0);

    // 5: error response on a write from req1; hresp during the address phase is ignored
    set_req(1, 1'b1, 32'h60, 32'h77);
    tick();
    check("err_ready", 64'(req_ready), 64'b10);
    req_valid = '0;
    hresp = 1'b1;
    tick();
    hresp = 1'b1;
    tick();
    check("err_rsp_valid", 64'(rsp_valid), 64'b10);
    check("err_rsp_err",   64'(rsp_err),   64'd1);
    hresp = 1'b0;
    tick();

    // 6: reset during a data-phase wait state
    set_req(0, 1'b0, 32'h80, 32'h0);
    tick();
    check("rst6_ready", 64'(req_ready), 64'b01);
    req_valid = '0;
    tick();
    hready = 1'b0;
    tick();
    hresetn = 1'b0;
    tick();
    check_reset_outputs("rst6");
    hresetn = 1'b1;
    hready  = 1'b1;
    set_req(0, 1'b0, 32'h90, 32'h0);
    set_req(1, 1'b0, 32'h94, 32'h0);
    tick();
    check("rst6_grant_req0", 64'(req_ready), 64'b01);
    check("rst6_no_stale_rsp", 64'(rsp_valid), 64'd0);
    req_valid = '0;
    tick();
    tick();
    check("rst6_rsp", 64'(rsp_valid), 64'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_req_arbiter.md
Name: ahb_req_arbiter

Overview:
- Shares one AHB-Lite master port between N_REQ requesters: non-pipelined, single transfers only.
- Picks a winner round-robin and runs its address phase, then its data phase, honouring hready wait states.
- Returns read data, or an error, to the winning requester only.
- Sits between test/traffic sources and the AHB bus interface; hclk and hresetn are shared with the bus.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, haddr width.
- DATA_W, 32, hwdata/hrdata width.
- TIMEOUT, 16, max data-phase wait cycles with hready low before abort (>=2).

Ports:
- hclk  in  1  bus clock; all logic on posedge.
- hresetn  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  requester i has a pending transfer.
- req_write  in  N_REQ  1=write, 0=read, per requester.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed write data.
- req_ready  out  N_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  N_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid.
- rsp_err  out  1  hresp error or timeout; valid with rsp_valid.
- haddr  out  ADDR_W  AHB address.
- hwrite  out  1  AHB direction.
- htrans  out  2  2'b00 IDLE, 2'b10 NONSEQ.
- hsize  out  3  fixed 3'b010 (word).
- hburst  out  3  fixed 3'b000 (SINGLE).
- hwdata  out  DATA_W  AHB write data.
- hrdata  in  DATA_W  AHB read data.
- hready  in  1  transfer done / slave ready.
- hresp  in  1  1=ERROR.

Behaviour:
- All outputs registered.
- Reset (hresetn==0 at posedge) takes effect that edge, including mid-transfer. Reset values:
  - state=IDLE, rr pointer=0;
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - haddr=0, hwrite=0, htrans=IDLE, hwdata=0.
  - hsize/hburst are constants.
  - An in-flight transfer is dropped with no response.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid: grant the first set bit at or after the rr pointer, wrapping from N_REQ-1 to 0.
  - Pulse req_ready[g] for one cycle.
  - Latch addr/write/wdata of g; drive haddr, hwrite, htrans=NONSEQ; go ADDR.
  - rr pointer <= (g+1) mod N_REQ.
  - No req_valid: stay in IDLE, htrans=IDLE.
- ADDR: on posedge with hready==1:
  - htrans<=IDLE.
  - If write, hwdata<=latched wdata.
  - Clear wait counter; go DATA.
  - hready==0: hold all bus outputs.
- DATA: on posedge with hready==1:
  - Pulse rsp_valid[g].
  - rsp_rdata<=hrdata for reads, 0 for writes.
  - rsp_err<=hresp; go IDLE.
  - hready==0: increment wait counter. When it reaches TIMEOUT: pulse rsp_valid[g], rsp_err=1, rsp_rdata=0, go IDLE.
- Zero-wait latency:
  - accept edge T (req_ready high after T);
  - NONSEQ sampled T+1;
  - data sampled T+2;
  - rsp_valid high after T+2.
  - Next grant can occur at the edge T+3, so throughput is 1 transfer / 3 cycles.
- Requester rules:
  - Must hold req_valid and its fields stable until req_ready.
  - Fields are ignored after accept.
  - Dropping req_valid before grant is legal.
- Simultaneous requests: exactly one grant per IDLE cycle. Every continuously-requesting requester is served within N_REQ grants.
- rsp_valid and req_ready are never both high in the same cycle.
- hresp is ignored in the ADDR state.

Decomposition:
- Package ahb_arb_pkg holds:
  - HTRANS_IDLE/HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE constants;
  - the arb_state_e enum;
  - addr/data typedefs parameterised by the default widths.
- One sub-module, ahb_rr_picker: combinational round-robin pick of (req_valid, rr pointer) -> one-hot grant + index + any.
- FSM, latches and timeout counter stay in ahb_req_arbiter.

Test Plan:
1. Write: req0 write addr 0x10 data 0xCAFE, hready=1 constantly -> req_ready[0] after edge T; haddr=0x10, htrans=2'b10, hwrite=1 at T+1; hwdata=0xCAFE at T+2; rsp_valid[0]=1, rsp_err=0 after T+2.
2. Read with waits: req1 read 0x20; slave holds hready=0 for 3 data-phase cycles, then returns 0x1234 -> rsp_valid[1] one cycle with rsp_rdata=0x1234, rsp_err=0; haddr held throughout.
3. Fairness: req0 and req1 valid continuously for 6 transfers -> grant order 0,1,0,1,0,1; no rsp_valid/req_ready overlap.
4. Timeout: read with hready stuck 0 in data phase, TIMEOUT=16 -> rsp_valid with rsp_err=1 and rsp_rdata=0 after the 16th low cycle; FSM back in IDLE, next request accepted.
5. Error: write with hresp=1 on the completing edge -> rsp_err=1 for that requester only.
6. Reset mid-DATA: hresetn=0 for 1 cycle during a wait state -> all outputs at reset values next cycle, no rsp_valid; pointer=0, so req1+req0 both valid afterwards grants req0 first.
